// File: rtl/hv_pwm_intb_encode_sched.sv
// ---------------------------------------------------------------------------
// hv_pwm_intb_encode_sched
// HV-side scheduler for the single PWM-encoded intb wire to the LV die.
// Set requests become a 1-low-pulse frame (assert intb); clear requests become
// a 3-low-pulse frame (release intb). Every frame closes with an idle-high gap.
// An optional refresh timer re-sends the current state after a quiet period.
//
// Ports:
//   i_clk            block clock
//   i_rst            synchronous reset, active-high
//   i_enable         1 = frames may start, 0 = hold in IDLE (pendings kept)
//   i_set_req        one-cycle request to assert intb
//   i_clr_req        one-cycle request to release intb
//   o_hv_pwm_intb_n  registered PWM line, idle high
//   o_busy           1 while a frame is in progress
//   o_set_ack        one-cycle pulse when a set frame completes
//   o_clr_ack        one-cycle pulse when a clear frame completes
//   o_intb_state     last state fully sent (1 = asserted)
// ---------------------------------------------------------------------------

// Elaboration-time legality checks on the timing parameters.
module hv_pwm_intb_encode_sched_chk #(
   parameter int LOW_CYC     = 6,
   parameter int HIGH_CYC    = 6,
   parameter int GAP_CYC     = 16,
   parameter int REFRESH_CYC = 1024,
   parameter int CNT_W       = 11
) ();
   if (LOW_CYC < 5 || LOW_CYC > 7) begin : g_bad_low
      $error("LOW_CYC must be in 5..7");
   end
   if (HIGH_CYC < 5 || HIGH_CYC > 7) begin : g_bad_high
      $error("HIGH_CYC must be in 5..7");
   end
   if (GAP_CYC < 12) begin : g_bad_gap
      $error("GAP_CYC must be >= 12");
   end
   if ((64'd1 << CNT_W) <= 64'(GAP_CYC) || (64'd1 << CNT_W) <= 64'(REFRESH_CYC)) begin : g_bad_cnt
      $error("CNT_W too narrow for GAP_CYC/REFRESH_CYC");
   end
endmodule

module hv_pwm_intb_encode_sched #(
   parameter int LOW_CYC     = 6,
   parameter int HIGH_CYC    = 6,
   parameter int GAP_CYC     = 16,
   parameter int REFRESH_CYC = 1024,
   parameter int CNT_W       = 11
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enable,
   input  logic i_set_req,
   input  logic i_clr_req,
   output logic o_hv_pwm_intb_n,
   output logic o_busy,
   output logic o_set_ack,
   output logic o_clr_ack,
   output logic o_intb_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOW = 2'd1, S_HIGH = 2'd2, S_GAP = 2'd3} state_t;
   typedef enum logic [1:0] {K_SET = 2'd0, K_CLR = 2'd1, K_REF = 2'd2} kind_t;

   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYC - 1);
   localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   // With refresh disabled the idle timer parks at zero and never matches.
   localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'((REFRESH_CYC > 0) ? (REFRESH_CYC - 1) : 0);
   localparam logic             REF_EN    = (REFRESH_CYC != 0) ? 1'b1 : 1'b0;

   state_t           r_state;
   kind_t            r_kind;
   logic [CNT_W-1:0] r_timer;
   logic [1:0]       r_pulse_left;
   logic             r_set_pend;
   logic             r_clr_pend;

   state_t           w_state_nxt;
   kind_t            w_kind_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic [1:0]       w_pulse_nxt;
   logic             w_set_eff;
   logic             w_clr_eff;
   logic             w_take_set;
   logic             w_take_clr;
   logic             w_done;

   hv_pwm_intb_encode_sched_chk #(
      .LOW_CYC(LOW_CYC), .HIGH_CYC(HIGH_CYC), .GAP_CYC(GAP_CYC),
      .REFRESH_CYC(REFRESH_CYC), .CNT_W(CNT_W)
   ) u_chk ();

   // Next-state, timer and frame bookkeeping.
   always_comb begin
      // A request arriving this cycle counts as pending right away; set wins
      // over clear, and a set (new or latched) cancels any latched clear.
      w_set_eff   = r_set_pend | i_set_req;
      w_clr_eff   = ~w_set_eff & (r_clr_pend | i_clr_req);
      w_state_nxt = r_state;
      w_kind_nxt  = r_kind;
      w_timer_nxt = r_timer;
      w_pulse_nxt = r_pulse_left;
      w_take_set  = 1'b0;
      w_take_clr  = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_enable && w_set_eff) begin
               w_state_nxt = S_LOW;
               w_timer_nxt = {CNT_W{1'b0}};
               w_pulse_nxt = 2'd1;
               w_kind_nxt  = K_SET;
               w_take_set  = 1'b1;
            end else if (i_enable && w_clr_eff) begin
               w_state_nxt = S_LOW;
               w_timer_nxt = {CNT_W{1'b0}};
               w_pulse_nxt = 2'd3;
               w_kind_nxt  = K_CLR;
               w_take_clr  = 1'b1;
            end else if (i_enable && REF_EN && (r_timer == REF_LAST)) begin
               w_state_nxt = S_LOW;
               w_timer_nxt = {CNT_W{1'b0}};
               w_pulse_nxt = o_intb_state ? 2'd1 : 2'd3;
               w_kind_nxt  = K_REF;
            end else if (i_enable && (r_timer < REF_LAST)) begin
               // Reaching here with i_enable=1 implies nothing is pending.
               w_timer_nxt = r_timer + 1'b1;
            end else begin
               w_timer_nxt = r_timer;
            end
         end
         S_LOW: begin
            if (r_timer == LOW_LAST) begin
               w_timer_nxt = {CNT_W{1'b0}};
               w_pulse_nxt = r_pulse_left - 2'd1;
               w_state_nxt = (r_pulse_left > 2'd1) ? S_HIGH : S_GAP;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_HIGH: begin
            if (r_timer == HIGH_LAST) begin
               w_timer_nxt = {CNT_W{1'b0}};
               w_state_nxt = S_LOW;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         S_GAP: begin
            if (r_timer == GAP_LAST) begin
               w_timer_nxt = {CNT_W{1'b0}};
               w_state_nxt = S_IDLE;
               w_done      = 1'b1;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = {CNT_W{1'b0}};
            w_pulse_nxt = 2'd0;
         end
      endcase
   end

   // State, pendings and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_kind          <= K_SET;
         r_timer         <= {CNT_W{1'b0}};
         r_pulse_left    <= 2'd0;
         r_set_pend      <= 1'b0;
         r_clr_pend      <= 1'b0;
         o_hv_pwm_intb_n <= 1'b1;
         o_busy          <= 1'b0;
         o_set_ack       <= 1'b0;
         o_clr_ack       <= 1'b0;
         o_intb_state    <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_kind          <= w_kind_nxt;
         r_timer         <= w_timer_nxt;
         r_pulse_left    <= w_pulse_nxt;
         r_set_pend      <= w_set_eff & ~w_take_set;
         r_clr_pend      <= w_clr_eff & ~w_take_clr;
         // Line and busy follow next-state so they change on the decision edge.
         o_hv_pwm_intb_n <= (w_state_nxt != S_LOW);
         o_busy          <= (w_state_nxt != S_IDLE);
         o_set_ack       <= w_done && (r_kind == K_SET);
         o_clr_ack       <= w_done && (r_kind == K_CLR);
         if (w_done && (r_kind == K_SET)) begin
            o_intb_state <= 1'b1;
         end else if (w_done && (r_kind == K_CLR)) begin
            o_intb_state <= 1'b0;
         end else begin
            o_intb_state <= o_intb_state;
         end
      end
   end

endmodule
